// File: rtl/decode_issue_stage_pkg.sv
// Shared decode constants, ALU operation codes and immediate helper for the
// decode/issue stage.
package decode_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_M    = 7'b0000001;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SLL  = 4'd1,
        SLT  = 4'd2,
        SLTU = 4'd3,
        XOR  = 4'd4,
        SRL  = 4'd5,
        OR   = 4'd6,
        AND  = 4'd7,
        SUB  = 4'd8,
        SRA  = 4'd9,
        MUL  = 4'd10,
        MULH = 4'd11,
        DIV  = 4'd12,
        REM  = 4'd13
    } opsel_e;

    function automatic logic [31:0] sext_imm_i(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

endpackage

// File: rtl/decode_issue_stage_scoreboard.sv
// Register-busy scoreboard: tracks in-flight destination registers and
// reports RAW/WAW hazards, with same-cycle writeback bypass.
module scoreboard
    import decode_pkg::*;
#(
    parameter  int unsigned NUM_REGS = 32,
    localparam int unsigned REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_set,
    input  logic [REG_AW-1:0] i_set_rd,
    input  logic              i_clr,
    input  logic [REG_AW-1:0] i_clr_rd,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    input  logic [REG_AW-1:0] i_rd,
    input  logic              i_chk_rs2,
    input  logic              i_chk_rd,
    output logic              o_hazard
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_busy_eff;
    logic [NUM_REGS-1:0] w_busy_next;

    // Writeback clears are applied before the lookup (bypass); a set after
    // the clear means a same-register set/clear leaves the bit busy.
    always_comb begin
        w_clr_mask = '0;
        w_set_mask = '0;
        if (i_clr) w_clr_mask[i_clr_rd] = 1'b1;
        if (i_set) w_set_mask[i_set_rd] = 1'b1;
        w_busy_eff    = r_busy & ~w_clr_mask;
        w_busy_eff[0] = 1'b0;
        w_busy_next    = w_busy_eff | w_set_mask;
        w_busy_next[0] = 1'b0;
    end

    assign o_hazard = w_busy_eff[i_rs1]
                    | (i_chk_rs2 & w_busy_eff[i_rs2])
                    | (i_chk_rd  & w_busy_eff[i_rd]);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

endmodule

// File: rtl/decode_issue_stage.sv
// Registered decode/issue stage: decodes RV32 R/I ALU instructions, stalls on
// scoreboard hazards and hands off to execute over a valid/ready pair.
module decode_issue_stage
    import decode_pkg::*;
#(
    parameter  int unsigned NUM_REGS    = 32,
    parameter  int unsigned OPSEL_W     = 4,
    parameter  int unsigned ENABLE_M    = 1,
    parameter  int unsigned STALL_CNT_W = 16,
    localparam int unsigned REG_AW      = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OPSEL_W-1:0]     out_opsel,
    output logic                   out_reg_write,
    output logic [REG_AW-1:0]      out_rd,
    output logic [REG_AW-1:0]      out_rs1,
    output logic [REG_AW-1:0]      out_rs2,
    output logic [31:0]            out_imm,
    output logic                   out_use_imm,
    output logic                   out_illegal,
    input  logic                   wb_valid,
    input  logic [REG_AW-1:0]      wb_rd,
    input  logic                   flush,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic [6:0]        w_opcode;
    logic [6:0]        w_f7;
    logic [2:0]        w_f3;
    logic [REG_AW-1:0] w_rd;
    logic [REG_AW-1:0] w_rs1;
    logic [REG_AW-1:0] w_rs2;
    logic              w_is_r;
    logic              w_is_i;
    opsel_e            w_opsel;
    logic              w_illegal;
    logic              w_reg_write;
    logic [31:0]       w_imm;
    logic              w_hazard;
    logic              w_accept;

    logic                   r_valid;
    logic [OPSEL_W-1:0]     r_opsel;
    logic                   r_reg_write;
    logic [REG_AW-1:0]      r_rd;
    logic [REG_AW-1:0]      r_rs1;
    logic [REG_AW-1:0]      r_rs2;
    logic [31:0]            r_imm;
    logic                   r_use_imm;
    logic                   r_illegal;
    logic [STALL_CNT_W-1:0] r_stall;

    assign w_opcode = in_instr[6:0];
    assign w_f3     = in_instr[14:12];
    assign w_f7     = in_instr[31:25];
    assign w_is_r   = (w_opcode == OP_R);
    assign w_is_i   = (w_opcode == OP_I);
    assign w_rd     = REG_AW'(in_instr[11:7]);
    assign w_rs1    = REG_AW'(in_instr[19:15]);
    assign w_rs2    = w_is_i ? '0 : REG_AW'(in_instr[24:20]);
    assign w_imm    = w_is_i ? sext_imm_i(in_instr) : '0;

    always_comb begin
        w_opsel   = ADD;
        w_illegal = 1'b0;
        unique case (1'b1)
            w_is_r: begin
                if (w_f7 == F7_BASE) begin
                    w_opsel = opsel_e'({1'b0, w_f3});
                end else if (w_f7 == F7_ALT && w_f3 == 3'b000) begin
                    w_opsel = SUB;
                end else if (w_f7 == F7_ALT && w_f3 == 3'b101) begin
                    w_opsel = SRA;
                end else if (w_f7 == F7_M && ENABLE_M != 0) begin
                    case (w_f3)
                        3'b000:  w_opsel = MUL;
                        3'b001:  w_opsel = MULH;
                        3'b100:  w_opsel = DIV;
                        3'b110:  w_opsel = REM;
                        default: w_illegal = 1'b1;
                    endcase
                end else begin
                    w_illegal = 1'b1;
                end
            end
            // Shift-immediates reuse imm[11:5] (the funct7 slot) as a qualifier.
            w_is_i: begin
                case (w_f3)
                    3'b001: begin
                        if (w_f7 == F7_BASE) w_opsel = SLL;
                        else                 w_illegal = 1'b1;
                    end
                    3'b101: begin
                        if (w_f7 == F7_BASE)     w_opsel = SRL;
                        else if (w_f7 == F7_ALT) w_opsel = SRA;
                        else                     w_illegal = 1'b1;
                    end
                    default: w_opsel = opsel_e'({1'b0, w_f3});
                endcase
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) w_opsel = ADD;
    end

    assign w_reg_write = !w_illegal && (w_rd != '0);

    scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (flush),
        .i_set     (w_accept & w_reg_write),
        .i_set_rd  (w_rd),
        .i_clr     (wb_valid),
        .i_clr_rd  (wb_rd),
        .i_rs1     (w_rs1),
        .i_rs2     (w_rs2),
        .i_rd      (w_rd),
        .i_chk_rs2 (w_is_r),
        .i_chk_rd  (w_reg_write),
        .o_hazard  (w_hazard)
    );

    assign in_ready = !rst && !flush && !w_hazard && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_opsel     <= '0;
            r_reg_write <= 1'b0;
            r_rd        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_imm       <= '0;
            r_use_imm   <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid     <= 1'b1;
            r_opsel     <= OPSEL_W'(w_opsel);
            r_reg_write <= w_reg_write;
            r_rd        <= w_rd;
            r_rs1       <= w_rs1;
            r_rs2       <= w_rs2;
            r_imm       <= w_imm;
            r_use_imm   <= w_is_i;
            r_illegal   <= w_illegal;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= '0;
        end else if (in_valid && w_hazard && !flush && !(&r_stall)) begin
            r_stall <= r_stall + STALL_CNT_W'(1);
        end
    end

    assign out_valid     = r_valid;
    assign out_opsel     = r_opsel;
    assign out_reg_write = r_reg_write;
    assign out_rd        = r_rd;
    assign out_rs1       = r_rs1;
    assign out_rs2       = r_rs2;
    assign out_imm       = r_imm;
    assign out_use_imm   = r_use_imm;
    assign out_illegal   = r_illegal;
    assign stall_count   = r_stall;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_decode_issue_stage;

    localparam int SCW     = 4;
    localparam int SAT_MAX = (1 << SCW) - 1;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, out_imm;
    logic [3:0]  out_opsel;
    logic        out_reg_write, out_use_imm, out_illegal;
    logic [4:0]  out_rd, out_rs1, out_rs2, wb_rd;
    logic        wb_valid, flush;
    logic [SCW-1:0] stall_count;

    logic        n_in_valid, n_in_ready, n_out_valid, n_out_reg_write;
    logic        n_out_use_imm, n_out_illegal;
    logic [3:0]  n_out_opsel;
    logic [4:0]  n_out_rd, n_out_rs1, n_out_rs2;
    logic [31:0] n_out_imm;
    logic [15:0] n_stall_count;

    decode_issue_stage #(
        .NUM_REGS(32), .OPSEL_W(4), .ENABLE_M(1), .STALL_CNT_W(SCW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
        .out_opsel(out_opsel), .out_reg_write(out_reg_write), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .out_use_imm(out_use_imm), .out_illegal(out_illegal),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .stall_count(stall_count)
    );

    decode_issue_stage #(
        .NUM_REGS(32), .OPSEL_W(4), .ENABLE_M(0), .STALL_CNT_W(16)
    ) dut_nom (
        .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .in_instr(in_instr), .out_valid(n_out_valid), .out_ready(1'b1),
        .out_opsel(n_out_opsel), .out_reg_write(n_out_reg_write), .out_rd(n_out_rd),
        .out_rs1(n_out_rs1), .out_rs2(n_out_rs2), .out_imm(n_out_imm),
        .out_use_imm(n_out_use_imm), .out_illegal(n_out_illegal),
        .wb_valid(1'b0), .wb_rd(5'd0), .flush(flush),
        .stall_count(n_stall_count)
    );

    typedef struct {
        bit [3:0]  op;
        bit        rw;
        bit [4:0]  rd, rs1, rs2;
        bit [31:0] imm;
        bit        ui;
        bit        ill;
        bit        is_r;
    } exp_t;

    int   n_vec = 0;
    int   n_err = 0;
    bit   m_busy [32];
    bit   m_valid;
    bit   m_show;
    exp_t m_out;
    int   m_stall;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Instruction meaning from the ISA tables: -1 marks an undecodable word.
    function automatic exp_t mdec(input bit [31:0] w);
        exp_t     e;
        bit [6:0] opc;
        bit [6:0] f7;
        bit [2:0] f3;
        int       op;
        int       m_ops [8];
        m_ops = '{10, 11, -1, -1, 12, -1, 13, -1};
        opc = w[6:0];
        f7  = w[31:25];
        f3  = w[14:12];
        op  = -1;
        e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
        e.imm = 0; e.ui = 0; e.is_r = (opc == 7'h33);
        if (opc == 7'h33) begin
            if (f7 == 7'h00)                  op = int'(f3);
            else if (f7 == 7'h20 && f3 == 0)  op = 8;
            else if (f7 == 7'h20 && f3 == 5)  op = 9;
            else if (f7 == 7'h01)             op = m_ops[f3];
        end else if (opc == 7'h13) begin
            e.rs2 = 0; e.ui = 1; e.imm = {{20{w[31]}}, w[31:20]};
            if (f3 == 1)      op = (f7 == 0) ? 1 : -1;
            else if (f3 == 5) op = (f7 == 0) ? 5 : ((f7 == 7'h20) ? 9 : -1);
            else              op = int'(f3);
        end
        e.ill = (op < 0);
        e.op  = e.ill ? 4'd0 : op[3:0];
        e.rw  = !e.ill && (e.rd != 0);
        return e;
    endfunction

    function automatic bit beff(input int r);
        return (r != 0) && m_busy[r] && !(wb_valid && int'(wb_rd) == r);
    endfunction

    function automatic bit m_hazard(input exp_t d);
        return beff(int'(d.rs1)) || (d.is_r && beff(int'(d.rs2))) || (d.rw && beff(int'(d.rd)));
    endfunction

    function automatic bit m_ready();
        return !rst && !flush && !m_hazard(mdec(in_instr)) && (!m_valid || out_ready);
    endfunction

    task automatic check_cycle();
        cmp("in_ready", in_ready, m_ready());
        cmp("out_valid", out_valid, m_valid);
        cmp("stall_count", stall_count, m_stall);
        if (m_valid || m_show) begin
            cmp("opsel", out_opsel, m_out.op);
            cmp("reg_write", out_reg_write, m_out.rw);
            cmp("rd", out_rd, m_out.rd);
            cmp("rs1", out_rs1, m_out.rs1);
            cmp("rs2", out_rs2, m_out.rs2);
            cmp("imm", out_imm, m_out.imm);
            cmp("use_imm", out_use_imm, m_out.ui);
            cmp("illegal", out_illegal, m_out.ill);
        end
    endtask

    task automatic model_update();
        exp_t d;
        bit   hz, acc;
        if (rst) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_valid = 0; m_show = 1; m_stall = 0;
            m_out = '{default: 0};
            return;
        end
        d   = mdec(in_instr);
        hz  = m_hazard(d);
        acc = in_valid && !flush && !hz && (!m_valid || out_ready);
        if (in_valid && hz && !flush && m_stall < SAT_MAX) m_stall++;
        if (flush) begin
            foreach (m_busy[i]) m_busy[i] = 0;
        end else begin
            if (wb_valid) m_busy[wb_rd] = 0;
            if (acc && d.rw) m_busy[d.rd] = 1;
        end
        if (flush) m_valid = 0;
        else if (acc) begin
            m_valid = 1; m_out = d; m_show = 0;
        end else if (out_ready) m_valid = 0;
    endtask

    task automatic tick();
        #1;
        check_cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    function automatic bit [4:0] rreg();
        return ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    function automatic bit [6:0] rf7();
        case ($urandom_range(0, 3))
            0:       return 7'h00;
            1:       return 7'h20;
            2:       return 7'h01;
            default: return 7'($urandom);
        endcase
    endfunction

    function automatic bit [31:0] rand_instr();
        int       k;
        bit [6:0] opc;
        k = $urandom_range(0, 9);
        if (k < 5)      opc = 7'h33;
        else if (k < 9) opc = 7'h13;
        else            opc = 7'($urandom);
        return {rf7(), rreg(), rreg(), 3'($urandom_range(0, 7)), rreg(), opc};
    endfunction

    initial begin
        rst = 1; in_valid = 0; in_instr = 0; out_ready = 0;
        wb_valid = 0; wb_rd = 0; flush = 0; n_in_valid = 0;
        @(negedge clk);
        @(posedge clk);
        model_update();
        @(negedge clk);
        tick();
        #1;
        cmp("rst_out_valid", out_valid, 0);
        cmp("rst_stall", stall_count, 0);
        cmp("rst_in_ready", in_ready, 0);
        rst = 0;
        tick();

        // ADD x3,x1,x2
        in_instr = 32'h002081B3; in_valid = 1; out_ready = 1; tick();
        in_valid = 0; #1;
        cmp("add_valid", out_valid, 1); cmp("add_opsel", out_opsel, 0);
        cmp("add_rw", out_reg_write, 1); cmp("add_rd", out_rd, 3);
        cmp("add_rs1", out_rs1, 1); cmp("add_rs2", out_rs2, 2);
        cmp("add_use_imm", out_use_imm, 0);

        // SUB x5,x3,x1 stalls on x3 until writeback bypass
        in_instr = 32'h401182B3; in_valid = 1; #1;
        cmp("sub_stall_ready", in_ready, 0);
        tick(); tick(); tick();
        #1; cmp("sub_stall_cnt", stall_count, 3);
        wb_valid = 1; wb_rd = 3; #1;
        cmp("sub_bypass_ready", in_ready, 1);
        tick();
        in_valid = 0; wb_valid = 0; #1;
        cmp("sub_opsel", out_opsel, 8); cmp("sub_rd", out_rd, 5);

        // ADDI x4,x0,-1
        in_instr = 32'hFFF00213; in_valid = 1; tick();
        in_valid = 0; #1;
        cmp("addi_opsel", out_opsel, 0); cmp("addi_use_imm", out_use_imm, 1);
        cmp("addi_imm", out_imm, 32'hFFFFFFFF); cmp("addi_rs1", out_rs1, 0);
        cmp("addi_rs2", out_rs2, 0); cmp("addi_rw", out_reg_write, 1);

        // Unknown opcode 0011011
        in_instr = 32'h0000001B; in_valid = 1; tick();
        in_valid = 0; #1;
        cmp("ill_flag", out_illegal, 1); cmp("ill_rw", out_reg_write, 0);
        cmp("ill_opsel", out_opsel, 0);

        // MUL x6,x1,x2 on both M-enabled and M-disabled instances
        in_instr = 32'h02208333; in_valid = 1; n_in_valid = 1; tick();
        in_valid = 0; n_in_valid = 0; #1;
        cmp("mul_opsel", out_opsel, 10); cmp("mul_illegal", out_illegal, 0);
        cmp("nom_valid", n_out_valid, 1); cmp("nom_illegal", n_out_illegal, 1);
        cmp("nom_opsel", n_out_opsel, 0); cmp("nom_rw", n_out_reg_write, 0);

        // Backpressure: ADD x3 held while ADDI x7,x0,5 waits
        in_instr = 32'h002081B3; in_valid = 1; out_ready = 1; tick();
        in_instr = 32'h00500393; out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            cmp("bp_ready", in_ready, 0); cmp("bp_valid", out_valid, 1);
            cmp("bp_rd", out_rd, 3); cmp("bp_opsel", out_opsel, 0);
            tick();
        end
        out_ready = 1; #1;
        cmp("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 0; #1;
        cmp("bp_next_rd", out_rd, 7); cmp("bp_next_imm", out_imm, 5);

        // Flush clears busy x3 so the dependent SUB issues without a stall
        in_instr = 32'h002081B3; in_valid = 1; wb_valid = 1; wb_rd = 3; #1;
        cmp("fl_add_ready", in_ready, 1);
        tick();
        in_valid = 0; wb_valid = 0; flush = 1; #1;
        cmp("fl_ready", in_ready, 0);
        tick();
        flush = 0; #1;
        cmp("fl_valid", out_valid, 0);
        in_instr = 32'h401182B3; in_valid = 1; #1;
        cmp("fl_sub_ready", in_ready, 1);
        tick();
        in_valid = 0; #1;
        cmp("fl_sub_opsel", out_opsel, 8); cmp("fl_sub_rd", out_rd, 5);
        cmp("fl_stall", stall_count, 3);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 49) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            wb_valid  = ($urandom_range(0, 2) == 0);
            wb_rd     = rreg();
            in_instr  = rand_instr();
            tick();
        end

        rst = 0; flush = 0; in_valid = 0; wb_valid = 0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Registered instruction-decode and issue stage for the RISC-V core. Sits between fetch and execute.
- Decodes a 32-bit instruction into the ALU operation select, register-write enable, register addresses, immediate and illegal flag.
- Holds a register-busy scoreboard that stalls issue on RAW/WAW hazards until writeback clears the register.
- Generalises the combinational control unit: parametrised opsel width, optional M-extension ops, valid/ready handshakes, flush and a stall counter.

Parameters:
- NUM_REGS, 32, architectural register count; REG_AW = clog2(NUM_REGS).
- OPSEL_W, 4, width of the ALU operation select.
- ENABLE_M, 1, when 0, funct7=0000001 R-type ops decode as illegal.
- STALL_CNT_W, 16, width of the saturating hazard-stall counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_instr  in  32  instruction word
- out_valid  out  1  decoded instruction available
- out_ready  in  1  execute consumes the instruction
- out_opsel  out  OPSEL_W  ALU operation code
- out_reg_write  out  1  instruction writes rd
- out_rd, out_rs1, out_rs2  out  REG_AW each  register addresses
- out_imm  out  32  sign-extended I-immediate, 0 for R-type
- out_use_imm  out  1  ALU operand B is out_imm
- out_illegal  out  1  undecodable instruction
- wb_valid  in  1  writeback retires a register write
- wb_rd  in  REG_AW  register being retired
- flush  in  1  discard the issued instruction and clear all busy bits
- stall_count  out  STALL_CNT_W  cycles with in_valid=1 blocked by a hazard

Behaviour:
- Reset: out_valid=0; all other out_* = 0; scoreboard all-clear; stall_count=0; in_ready=0 during reset.
- Opsel map, R-type (0110011):
  - funct7=0000000: f3 000..111 map to ADD 0, SLL 1, SLT 2, SLTU 3, XOR 4, SRL 5, OR 6, AND 7.
  - funct7=0100000: f3 000 maps to SUB 8; f3 101 maps to SRA 9.
  - funct7=0000001 (ENABLE_M=1): f3 000 MUL 10, 001 MULH 11, 100 DIV 12, 110 REM 13.
  - Any other funct7/funct3 combination is illegal.
- Opsel map, I-type (0010011):
  - f3 values map to the same codes as the matching R-type op, with use_imm=1.
  - SLLI/SRLI require imm[11:5]=0000000; SRAI requires 0100000; otherwise illegal.
  - rs2 is reported as 0 and is not hazard-checked.
- Any other opcode is illegal.
- Illegal instruction: out_illegal=1, out_opsel=0, out_reg_write=0; no scoreboard bit is set. It still issues.
- reg_write=1 for legal R/I ops with rd≠0; rd=x0 gives reg_write=0.
- Hazard:
  - busy_eff = scoreboard with the wb_valid/wb_rd bit masked the same cycle (writeback bypass).
  - hazard = busy_eff[rs1] | (R-type & busy_eff[rs2]) | (reg_write & busy_eff[rd]).
  - x0 is never busy.
- Handshake and latency:
  - in_ready = !rst & !flush & !hazard & (!out_valid | out_ready).
  - Accept (in_valid & in_ready) registers the decode; out_valid=1 the next cycle (1-cycle latency).
  - If out_valid & out_ready and no accept, out_valid clears next cycle.
  - Outputs hold stable while out_valid & !out_ready.
- Scoreboard:
  - An accept with reg_write sets busy[rd].
  - wb_valid clears busy[wb_rd].
  - Simultaneous set and clear of the same rd: set wins.
  - A wb to a non-busy register is ignored.
- flush: next cycle out_valid=0 and scoreboard all-clear. No accept in the flush cycle. A simultaneous wb is irrelevant.
- stall_count increments when in_valid & hazard & !flush; it saturates at all-ones.
- Reset asserted mid-operation returns every output to its reset value on the next edge.

Decomposition:
- Shared package decode_pkg holds:
  - opcode constants OP_R=0110011, OP_I=0010011;
  - funct7 constants F7_BASE, F7_ALT=0100000, F7_M=0000001;
  - the opsel enum ADD..REM (values 0..13).
- One sub-module, scoreboard (NUM_REGS-bit busy vector with set/clear/flush and hazard lookup).
- The decode logic is combinational inside the top level.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), out_ready=1, in_valid for 1 cycle -> one cycle later out_valid=1, opsel=0, reg_write=1, rd=3, rs1=1, rs2=2, use_imm=0; busy[3] set.
- Then SUB x5,x3,x1 (0x401182B3) with no wb -> in_ready=0 and stall_count increments each cycle. Then wb_valid=1, wb_rd=3 -> accepted the same cycle (bypass); next cycle opsel=8, rd=5.
- ADDI x4,x0,-1 (0xFFF00213) -> opsel=0, use_imm=1, imm=0xFFFFFFFF, rs1=0, rs2=0, reg_write=1.
- 0x0000001B (opcode 0011011) -> out_illegal=1, reg_write=0, opsel=0, scoreboard unchanged. MUL x6,x1,x2 (0x02208333) gives opsel=10 with ENABLE_M=1, and illegal with ENABLE_M=0.
- ADD x3,x1,x2 with out_ready=0 held for 3 cycles -> outputs stable, in_ready=0; the next instruction is accepted in the cycle out_ready=1.
- Issue ADD writing x3, then assert flush for 1 cycle -> out_valid=0, busy[3] cleared; SUB x5,x3,x1 is then accepted without stall.
